// File: rtl/stream_upsizer.sv
// rtl/stream_upsizer.sv - packs RATIO narrow input beats into one wide output word
// Lanes fill from 0 upward; a word closes on the last lane or on a packet's last beat.
module stream_upsizer #(
   parameter int DATA_SIZE = 8,
   parameter int RATIO     = 4
) (
   input  logic                          clk_i,
   input  logic                          rst_clk_ni,
   input  logic [DATA_SIZE-1:0]          data_i,
   input  logic                          data_last_i,
   input  logic                          data_valid_i,
   output logic                          data_ready_o,
   output logic [DATA_SIZE*RATIO-1:0]    data_o,
   output logic [RATIO-1:0]              data_keep_o,
   output logic                          data_last_o,
   output logic                          data_valid_o,
   input  logic                          data_ready_i
);

   localparam int IW = $clog2(RATIO);
   localparam logic [IW-1:0] LAST_IDX = IW'(RATIO - 1);

   localparam logic ST_COLLECT = 1'b0;
   localparam logic ST_HOLD    = 1'b1;

   generate
      if (RATIO < 2 || RATIO > 16) begin : g_bad_ratio
         $error("stream_upsizer: RATIO must be in 2..16");
      end
   endgenerate

   logic                       state_q, state_d;
   logic [IW-1:0]              idx_q, idx_d;
   logic [DATA_SIZE*RATIO-1:0] data_q, data_d;
   logic [RATIO-1:0]           keep_q, keep_d;
   logic                       last_q, last_d;
   logic                       accept;

   // Held low during reset so no beat can be accepted before the block is live.
   assign data_ready_o = rst_clk_ni & ((state_q == ST_COLLECT) | data_ready_i);
   assign accept       = data_valid_i & data_ready_o;

   assign data_o       = data_q;
   assign data_keep_o  = keep_q;
   assign data_last_o  = last_q;
   assign data_valid_o = (state_q == ST_HOLD);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      data_d  = data_q;
      keep_d  = keep_q;
      last_d  = last_q;
      case (state_q)
         ST_COLLECT: begin
            if (accept) begin
               data_d[int'(idx_q)*DATA_SIZE +: DATA_SIZE] = data_i;
               keep_d[idx_q] = 1'b1;
               idx_d         = idx_q + IW'(1);
               if (idx_q == LAST_IDX || data_last_i) begin
                  state_d = ST_HOLD;
                  last_d  = data_last_i;
                  idx_d   = '0;
               end
            end
         end
         default: begin
            if (data_ready_i) begin
               state_d = ST_COLLECT;
               data_d  = '0;
               keep_d  = '0;
               last_d  = 1'b0;
               idx_d   = '0;
               // A beat taken in the transfer cycle starts the next word in lane 0.
               if (accept) begin
                  data_d[DATA_SIZE-1:0] = data_i;
                  keep_d[0]             = 1'b1;
                  idx_d                 = IW'(1);
                  if (data_last_i) begin
                     state_d = ST_HOLD;
                     last_d  = 1'b1;
                     idx_d   = '0;
                  end
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_clk_ni) begin
      if (!rst_clk_ni) begin
         state_q <= ST_COLLECT;
         idx_q   <= '0;
         data_q  <= '0;
         keep_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         keep_q  <= keep_d;
         last_q  <= last_d;
      end
   end

endmodule

// File: tb/tb_stream_upsizer.sv
// tb/tb_stream_upsizer.sv - bench for stream_upsizer (DATA_SIZE=8, RATIO=4)
module tb_stream_upsizer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  data_i;
   logic        data_last_i;
   logic        data_valid_i;
   logic        data_ready_o;
   logic [31:0] data_o;
   logic [3:0]  data_keep_o;
   logic        data_last_o;
   logic        data_valid_o;
   logic        data_ready_i;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   stream_upsizer #(.DATA_SIZE(8), .RATIO(4)) dut (
      .clk_i        (clk),
      .rst_clk_ni   (rst_n),
      .data_i       (data_i),
      .data_last_i  (data_last_i),
      .data_valid_i (data_valid_i),
      .data_ready_o (data_ready_o),
      .data_o       (data_o),
      .data_keep_o  (data_keep_o),
      .data_last_o  (data_last_o),
      .data_valid_o (data_valid_o),
      .data_ready_i (data_ready_i)
   );

   typedef struct {
      logic        v;
      logic [7:0]  d;
      logic        l;
      logic        r;
      logic        ev;
      logic        er;
      logic [31:0] ed;
      logic [3:0]  ek;
      logic        el;
   } vec_t;

   typedef struct {
      logic [7:0] d;
      logic       l;
   } beat_t;

   typedef struct {
      logic [31:0] d;
      logic [3:0]  k;
      logic        l;
   } word_t;

   vec_t  tbl[$];
   beat_t beat_q[$];
   word_t exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic vec_t mkv(input logic v, input logic [7:0] d, input logic l, input logic r,
                                input logic ev, input logic er, input logic [31:0] ed,
                                input logic [3:0] ek, input logic el);
      vec_t t;
      t.v = v; t.d = d; t.l = l; t.r = r;
      t.ev = ev; t.er = er; t.ed = ed; t.ek = ek; t.el = el;
      return t;
   endfunction

   // Reference packing: fill lanes in order, emit on the 4th lane or on last.
   task automatic model_pack();
      int n = 0;
      word_t w;
      w.d = '0; w.k = '0; w.l = 1'b0;
      foreach (beat_q[i]) begin
         w.d[n*8 +: 8] = beat_q[i].d;
         w.k[n] = 1'b1;
         n++;
         if (n == 4 || beat_q[i].l) begin
            w.l = beat_q[i].l;
            exp_q.push_back(w);
            n = 0;
            w.d = '0; w.k = '0; w.l = 1'b0;
         end
      end
   endtask

   task automatic add_packet(input int len, input logic [7:0] base, input bit rnd);
      beat_t b;
      for (int i = 0; i < len; i++) begin
         b.d = rnd ? 8'($urandom) : base + 8'(i);
         b.l = (i == len - 1);
         beat_q.push_back(b);
      end
   endtask

   task automatic run_sb(input bit rnd, input int max_cycles, output int cyc, output int nvalid);
      cyc = 0;
      nvalid = 0;
      while ((beat_q.size() > 0 || exp_q.size() > 0) && cyc < max_cycles) begin
         data_valid_i = (beat_q.size() > 0) && (!rnd || $urandom_range(0, 3) != 0);
         data_i       = (beat_q.size() > 0) ? beat_q[0].d : 8'h00;
         data_last_i  = (beat_q.size() > 0) ? beat_q[0].l : 1'b0;
         data_ready_i = !rnd || $urandom_range(0, 3) != 0;
         @(negedge clk);
         if (data_valid_o) begin
            nvalid++;
            if (exp_q.size() == 0) begin
               chk("sb_extra_word", {31'd0, data_valid_o}, 32'd0);
            end else begin
               chk("sb_data", data_o, exp_q[0].d);
               chk("sb_keep", {28'd0, data_keep_o}, {28'd0, exp_q[0].k});
               chk("sb_last", {31'd0, data_last_o}, {31'd0, exp_q[0].l});
               if (data_ready_i) void'(exp_q.pop_front());
            end
         end
         if (data_valid_i && data_ready_o) void'(beat_q.pop_front());
         @(posedge clk);
         #1;
         cyc++;
      end
      data_valid_i = 1'b0;
      data_last_i  = 1'b0;
      chk("sb_timeout", {31'd0, cyc >= max_cycles}, 32'd0);
      chk("sb_words_left", exp_q.size(), 32'd0);
      beat_q.delete();
      exp_q.delete();
   endtask

   initial begin
      int cyc, nv;
      rst_n = 1'b0;
      data_i = '0; data_last_i = 1'b0; data_valid_i = 1'b0; data_ready_i = 1'b0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", {31'd0, data_valid_o}, 32'd0);
      chk("rst_ready", {31'd0, data_ready_o}, 32'd0);
      chk("rst_data", data_o, 32'd0);
      chk("rst_keep", {28'd0, data_keep_o}, 32'd0);
      chk("rst_last", {31'd0, data_last_o}, 32'd0);

      // Directed cycle table: full word, short packet, single-beat pair, back-pressure.
      tbl.push_back(mkv(1, 8'h11, 0, 1, 0, 1, 32'h00000000, 4'h0, 0));
      tbl.push_back(mkv(1, 8'h22, 0, 1, 0, 1, 32'h00000011, 4'h1, 0));
      tbl.push_back(mkv(1, 8'h33, 0, 1, 0, 1, 32'h00002211, 4'h3, 0));
      tbl.push_back(mkv(1, 8'h44, 1, 1, 0, 1, 32'h00332211, 4'h7, 0));
      tbl.push_back(mkv(1, 8'hA1, 0, 1, 1, 1, 32'h44332211, 4'hF, 1));
      tbl.push_back(mkv(1, 8'hA2, 1, 1, 0, 1, 32'h000000A1, 4'h1, 0));
      tbl.push_back(mkv(0, 8'h00, 0, 1, 1, 1, 32'h0000A2A1, 4'h3, 1));
      tbl.push_back(mkv(0, 8'h00, 0, 1, 0, 1, 32'h00000000, 4'h0, 0));
      tbl.push_back(mkv(1, 8'hEE, 1, 1, 0, 1, 32'h00000000, 4'h0, 0));
      tbl.push_back(mkv(1, 8'hFF, 1, 1, 1, 1, 32'h000000EE, 4'h1, 1));
      tbl.push_back(mkv(0, 8'h00, 0, 1, 1, 1, 32'h000000FF, 4'h1, 1));
      tbl.push_back(mkv(1, 8'hB1, 0, 1, 0, 1, 32'h00000000, 4'h0, 0));
      tbl.push_back(mkv(1, 8'hB2, 0, 1, 0, 1, 32'h000000B1, 4'h1, 0));
      tbl.push_back(mkv(1, 8'hB3, 0, 1, 0, 1, 32'h0000B2B1, 4'h3, 0));
      tbl.push_back(mkv(1, 8'hB4, 0, 1, 0, 1, 32'h00B3B2B1, 4'h7, 0));
      for (int i = 0; i < 5; i++)
         tbl.push_back(mkv(1, 8'hC1, 1, 0, 1, 0, 32'hB4B3B2B1, 4'hF, 0));
      tbl.push_back(mkv(1, 8'hC1, 1, 1, 1, 1, 32'hB4B3B2B1, 4'hF, 0));
      tbl.push_back(mkv(0, 8'h00, 0, 1, 1, 1, 32'h000000C1, 4'h1, 1));
      tbl.push_back(mkv(0, 8'h00, 0, 1, 0, 1, 32'h00000000, 4'h0, 0));

      @(posedge clk);
      #1;
      rst_n = 1'b1;
      foreach (tbl[i]) begin
         data_valid_i = tbl[i].v;
         data_i       = tbl[i].d;
         data_last_i  = tbl[i].l;
         data_ready_i = tbl[i].r;
         @(negedge clk);
         chk($sformatf("tbl%0d_valid", i), {31'd0, data_valid_o}, {31'd0, tbl[i].ev});
         chk($sformatf("tbl%0d_ready", i), {31'd0, data_ready_o}, {31'd0, tbl[i].er});
         chk($sformatf("tbl%0d_data", i), data_o, tbl[i].ed);
         chk($sformatf("tbl%0d_keep", i), {28'd0, data_keep_o}, {28'd0, tbl[i].ek});
         chk($sformatf("tbl%0d_last", i), {31'd0, data_last_o}, {31'd0, tbl[i].el});
         @(posedge clk);
         #1;
      end

      // Reset mid-packet: partial 0x55,0x66 must vanish.
      data_valid_i = 1'b1; data_last_i = 1'b0; data_ready_i = 1'b1; data_i = 8'h55;
      @(posedge clk); #1;
      data_i = 8'h66;
      @(posedge clk); #1;
      rst_n = 1'b0;
      data_valid_i = 1'b0;
      @(negedge clk);
      chk("midrst_data", data_o, 32'd0);
      chk("midrst_ready", {31'd0, data_ready_o}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      data_valid_i = 1'b1; data_i = 8'h77; data_last_i = 1'b1;
      @(negedge clk);
      chk("midrst_ready_after", {31'd0, data_ready_o}, 32'd1);
      @(posedge clk); #1;
      data_valid_i = 1'b0; data_last_i = 1'b0;
      @(negedge clk);
      chk("midrst_valid", {31'd0, data_valid_o}, 32'd1);
      chk("midrst_word", data_o, 32'h00000077);
      chk("midrst_keep", {28'd0, data_keep_o}, 32'h1);
      chk("midrst_last", {31'd0, data_last_o}, 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("midrst_no_second", {31'd0, data_valid_o}, 32'd0);
      @(posedge clk); #1;

      // Streaming: 12 beats, 3 words, no bubbles.
      add_packet(12, 8'h01, 1'b0);
      model_pack();
      chk("stream_model_w0", exp_q[0].d, 32'h04030201);
      run_sb(1'b0, 100, cyc, nv);
      chk("stream_cycles", cyc, 32'd13);
      chk("stream_nvalid", nv, 32'd3);

      // Randomised packets with random valid/ready.
      for (int p = 0; p < 60; p++) add_packet($urandom_range(1, 10), 8'h00, 1'b1);
      model_pack();
      run_sb(1'b1, 5000, cyc, nv);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/stream_upsizer.md
STREAM_UPSIZER -- requirements
Module: stream_upsizer

Interface
REQ-001 The block SHALL have parameter DATA_SIZE, default 8, giving the width of one input beat in bits.
REQ-002 The block SHALL have parameter RATIO, default 4, giving the number of input beats per output word; the legal range is 2..16.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_clk_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port data_i, input, DATA_SIZE bits: the input beat.
REQ-006 The block SHALL have port data_last_i, input, 1 bit: marks the final beat of a packet.
REQ-007 The block SHALL have port data_valid_i, input, 1 bit: the input beat is valid.
REQ-008 The block SHALL have port data_ready_o, output, 1 bit: the block accepts the input beat.
REQ-009 The block SHALL have port data_o, output, DATA_SIZE*RATIO bits: the packed word; beat k sits at bits [k*DATA_SIZE +: DATA_SIZE].
REQ-010 The block SHALL have port data_keep_o, output, RATIO bits: bit k is 1 when lane k holds a real beat.
REQ-011 The block SHALL have port data_last_o, output, 1 bit: the word closes a packet.
REQ-012 The block SHALL have port data_valid_o, output, 1 bit: the output word is valid.
REQ-013 The block SHALL have port data_ready_i, input, 1 bit: downstream accepts the word.

Function
REQ-014 An input beat SHALL be accepted when data_valid_i && data_ready_o; an output word SHALL be transferred when data_valid_o && data_ready_i.
REQ-015 The FSM SHALL have exactly two states: StCollect (filling lanes) and StHold (complete word presented).
REQ-016 A lane index register, ceil(log2(RATIO)) bits wide, SHALL select the lane written by each accepted beat, starting at 0.
REQ-017 In StCollect: data_ready_o=1 and data_valid_o=0. On each accepted beat: write the lane, set its keep bit, increment the index.
REQ-018 In StCollect, acceptance at index RATIO-1 or with data_last_i=1 SHALL move the FSM to StHold, set data_last_o=data_last_i, and reset the index to 0.
REQ-019 In StHold: data_valid_o=1, and data_o, data_keep_o and data_last_o SHALL stay stable until the transfer; data_ready_o=data_ready_i.
REQ-020 In StHold, a transfer with no accepted input SHALL clear all lanes and keep bits to 0 and return the FSM to StCollect.
REQ-021 In StHold, a transfer with a simultaneously accepted beat SHALL clear the word and place that beat in lane 0 with keep=...0001 and index=1.
REQ-022 If the beat in REQ-021 carries last, or RATIO would be reached, the FSM SHALL stay in StHold with the new word instead.
REQ-023 Lanes not written in the current word SHALL read as zero, and their keep bits SHALL be 0.
REQ-024 Latency: the output SHALL become valid exactly 1 cycle after the completing beat is accepted; full throughput SHALL be 1 word per RATIO cycles with no bubbles.
REQ-025 A beat with data_last_i=1 at index 0 SHALL produce a word with keep=...0001 and last=1.
REQ-026 A packet whose length is a multiple of RATIO SHALL have last=1 only on its final word, with every keep bit set.
REQ-027 Input data_i, data_last_i and data_valid_i SHALL have no combinational path to any output except via data_ready_o=data_ready_i in StHold.

Reset
REQ-028 While rst_clk_ni=0: state=StCollect, index=0, data_o=0, data_keep_o=0, data_last_o=0, data_valid_o=0, data_ready_o=0.
REQ-029 Reset asserted mid-packet SHALL discard the partial word, and no output word SHALL be produced from it after release.
REQ-030 data_ready_o SHALL first go to 1 in the first cycle after rst_clk_ni deasserts.

Verification (DATA_SIZE=8, RATIO=4)
REQ-031 Full word: beats 0x11,0x22,0x33,0x44 (last on 0x44), ready_i=1 -> 1 cycle later data_o=0x44332211, keep=4'hF, last=1, valid 1 cycle.
REQ-032 Short packet: beats 0xA1,0xA2 with last on 0xA2 -> data_o=0x0000A2A1, keep=4'h3, last=1.
REQ-033 Back-pressure: ready_i=0 for 5 cycles while the word is held -> output stable; data_ready_o=0; no beat lost; next word correct after release.
REQ-034 Streaming: 12 continuous beats 0x01..0x0C (last on 0x0C), ready_i=1 -> 3 words 0x04030201, 0x08070605, 0x0C0B0A09, no bubbles, last only on the third.
REQ-035 Reset mid-packet: accept 0x55,0x66, assert reset, then send 0x77 with last -> single word 0x00000077, keep=4'h1.
REQ-036 Single-beat packets: 0xEE(last), 0xFF(last) back-to-back -> two words, keep=4'h1, last=1, the second taken during the first's transfer cycle.
